// File: rtl/tdc_stamp_unit.sv
// -----------------------------------------------------------------------------
// tdc_stamp_unit
//
// Back end for a tapped-delay-line time-to-digital converter. The raw
// carry-chain thermometer vector is sampled every clock, edges on tap 0 are
// detected as hits, and each hit is turned into a timestamp made of a
// free-running coarse count plus a fine position. The fine position is a full
// popcount of the taps that agree with tap 0, so isolated bubbles in the
// thermometer code do not corrupt it. Timestamps are queued in a
// first-word-fall-through FIFO with a valid/ready output handshake.
//
// Ports
//   CLK         sampling / system clock
//   RST_N       asynchronous active-low reset
//   EN          1 = coarse counter runs and hits are recorded
//   CLEAR       synchronous flush (FIFO, coarse counter, drop counter, encode)
//   TAP         raw carry-chain outputs, asynchronous to CLK
//   OUT_DATA    FIFO head {pol, sat, coarse, fine}, 0 when empty
//   OUT_VALID   FIFO head valid
//   OUT_READY   consumer accepts the head entry
//   FIFO_LEVEL  number of occupied FIFO entries
//   DROP_CNT    hits lost to a full FIFO, saturating at 255
// -----------------------------------------------------------------------------
module tdc_stamp_unit #(
  parameter int  NTAPS     = 128,
  parameter int  CW        = 16,
  parameter int  DEPTH     = 8,
  parameter int  EDGE_MODE = 0,
  localparam int FW        = $clog2(NTAPS + 1),
  localparam int AW        = $clog2(DEPTH),
  localparam int DW        = CW + FW + 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             CLEAR,
  input  logic [NTAPS-1:0] TAP,
  output logic [DW-1:0]    OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [AW:0]      FIFO_LEVEL,
  output logic [7:0]       DROP_CNT
);

  localparam bit ACCEPT_RISE = (EDGE_MODE != 1);
  localparam bit ACCEPT_FALL = (EDGE_MODE != 0);

  // Sample pipeline. s1/s2 synchronise the asynchronous tap vector; only
  // tap 0 of the third stage is needed, since it exists purely for edge
  // detection against s2.
  logic [NTAPS-1:0] s1;
  logic [NTAPS-1:0] s2;
  logic             s3;

  // Coarse counter and the copies that travel alongside s1/s2, so a hit is
  // stamped with the count that was loaded on the edge capturing TAP.
  logic [CW-1:0] coarse;
  logic [CW-1:0] coarse_d;
  logic [CW-1:0] c1;
  logic [CW-1:0] c2;

  logic          rise;
  logic          fall;
  logic          hit;
  logic [FW-1:0] match_cnt;
  logic          sat;

  logic          enc_valid;
  logic [DW-1:0] enc_data;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    drop_cnt;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_ok;
  logic          drop;

  // Next coarse value; the copy c1 takes this same value so the stamp matches
  // the counter as it stands right after the capture edge.
  always_comb begin
    coarse_d = coarse;
    if (CLEAR) begin
      coarse_d = '0;
    end else if (EN) begin
      coarse_d = coarse + 1'b1;
    end
  end

  // Coarse counter register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      coarse <= '0;
    end else begin
      coarse <= coarse_d;
    end
  end

  // Tap sampling and coarse copies run every cycle regardless of EN or CLEAR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= 1'b0;
      c1 <= '0;
      c2 <= '0;
    end else begin
      s1 <= TAP;
      s2 <= s1;
      s3 <= s2[0];
      c1 <= coarse_d;
      c2 <= c1;
    end
  end

  assign rise = s2[0] & ~s3;
  assign fall = ~s2[0] & s3;
  assign hit  = EN & ((rise & ACCEPT_RISE) | (fall & ACCEPT_FALL));

  // Full popcount of taps agreeing with tap 0; counting every tap rather than
  // searching for the first transition is what makes bubbles harmless.
  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < NTAPS; i++) begin
      match_cnt = match_cnt + FW'(s2[i] ~^ s2[0]);
    end
  end

  assign sat = (match_cnt == FW'(NTAPS));

  // Encode stage. A hit seen in the same cycle as CLEAR is thrown away.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      enc_valid <= 1'b0;
      enc_data  <= '0;
    end else if (CLEAR) begin
      enc_valid <= 1'b0;
    end else begin
      enc_valid <= hit;
      if (hit) begin
        enc_data <= {s2[0], sat, c2, match_cnt};
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = ~empty & OUT_READY;
  // A full FIFO still takes the write if the head leaves on the same edge.
  assign wr_ok = enc_valid & (~full | pop);
  assign drop  = enc_valid & full & ~pop;

  // Storage array; contents never need a reset because OUT_DATA is forced to
  // zero whenever the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (wr_ok && !CLEAR) begin
      mem[wr_ptr] <= enc_data;
    end
  end

  // FIFO pointers, occupancy and the saturating drop counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (CLEAR) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign OUT_VALID  = ~empty;
  assign OUT_DATA   = empty ? '0 : mem[rd_ptr];
  assign FIFO_LEVEL = count;
  assign DROP_CNT   = drop_cnt;

endmodule

// File: tb/tb_tdc_stamp_unit.sv
// -----------------------------------------------------------------------------
// tb_tdc_stamp_unit
//
// Two instances share every input: one accepts rising hits only, the other
// accepts both edges. Each driven tap change pushes the expected stamp onto a
// per-instance scoreboard queue (or counts an expected drop when that queue
// already holds a full FIFO's worth with the consumer stalled); a monitor
// pops and compares whenever an instance hands over its head entry.
// -----------------------------------------------------------------------------
module tb_tdc_stamp_unit;

  localparam int NTAPS = 16;
  localparam int CW    = 8;
  localparam int DEPTH = 4;
  localparam int FW    = 5;
  localparam int DW    = CW + FW + 2;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             EN;
  logic             CLEAR;
  logic             OUT_READY;
  logic [NTAPS-1:0] TAP;

  logic [DW-1:0] data_r, data_b;
  logic          valid_r, valid_b;
  logic [2:0]    level_r, level_b;
  logic [7:0]    drop_r, drop_b;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [DW-1:0]    q_r[$];
  logic [DW-1:0]    q_b[$];
  int               exp_drop_r = 0;
  int               exp_drop_b = 0;
  logic [CW-1:0]    m_coarse = '0;
  logic [NTAPS-1:0] tap_prev = '0;

  always #5 CLK = ~CLK;

  tdc_stamp_unit #(.NTAPS(NTAPS), .CW(CW), .DEPTH(DEPTH), .EDGE_MODE(0)) dut_r (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLEAR(CLEAR), .TAP(TAP),
    .OUT_DATA(data_r), .OUT_VALID(valid_r), .OUT_READY(OUT_READY),
    .FIFO_LEVEL(level_r), .DROP_CNT(drop_r)
  );

  tdc_stamp_unit #(.NTAPS(NTAPS), .CW(CW), .DEPTH(DEPTH), .EDGE_MODE(2)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLEAR(CLEAR), .TAP(TAP),
    .OUT_DATA(data_b), .OUT_VALID(valid_b), .OUT_READY(OUT_READY),
    .FIFO_LEVEL(level_b), .DROP_CNT(drop_b)
  );

  // Reference coarse counter: zero on reset/clear, +1 per enabled edge.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) m_coarse = '0;
    else if (CLEAR) m_coarse = '0;
    else if (EN) m_coarse = m_coarse + 8'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] expectedStamp(input logic [NTAPS-1:0] tap, input logic [CW-1:0] coarse);
    int m = 0;
    for (int i = 0; i < NTAPS; i++) if (tap[i] == tap[0]) m++;
    return {tap[0], (m == NTAPS), coarse, FW'(m)};
  endfunction

  // Drive a tap value right after an edge, so the next edge captures it.
  task automatic applyStimulus(input logic [NTAPS-1:0] tap, input int hold, input bit force_accept);
    logic [DW-1:0] stamp;
    logic          rise, fall;
    rise  = tap[0] & ~tap_prev[0];
    fall  = ~tap[0] & tap_prev[0];
    stamp = expectedStamp(tap, EN ? m_coarse + 8'd1 : m_coarse);
    if (EN && rise) begin
      if (!force_accept && !OUT_READY && q_r.size() >= DEPTH) begin
        if (exp_drop_r < 255) exp_drop_r++;
      end else q_r.push_back(stamp);
    end
    if (EN && (rise || fall)) begin
      if (!force_accept && !OUT_READY && q_b.size() >= DEPTH) begin
        if (exp_drop_b < 255) exp_drop_b++;
      end else q_b.push_back(stamp);
    end
    TAP      = tap;
    tap_prev = tap;
    repeat (hold) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic checkIdle(input string pfx);
    checkOutput({pfx, "_valid_r"}, 32'(valid_r), 32'd0);
    checkOutput({pfx, "_data_r"},  32'(data_r),  32'd0);
    checkOutput({pfx, "_level_r"}, 32'(level_r), 32'd0);
    checkOutput({pfx, "_drop_r"},  32'(drop_r),  32'd0);
    checkOutput({pfx, "_valid_b"}, 32'(valid_b), 32'd0);
    checkOutput({pfx, "_data_b"},  32'(data_b),  32'd0);
    checkOutput({pfx, "_level_b"}, 32'(level_b), 32'd0);
    checkOutput({pfx, "_drop_b"},  32'(drop_b),  32'd0);
  endtask

  task automatic waitDrain(input string pfx);
    int cyc = 0;
    OUT_READY = 1'b1;
    while ((q_r.size() != 0 || q_b.size() != 0) && cyc < 200) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    checkOutput({pfx, "_left_r"}, 32'(q_r.size()), 32'd0);
    checkOutput({pfx, "_left_b"}, 32'(q_b.size()), 32'd0);
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    checkOutput({pfx, "_level_r"}, 32'(level_r), 32'd0);
    checkOutput({pfx, "_level_b"}, 32'(level_b), 32'd0);
    checkOutput({pfx, "_drop_r"},  32'(drop_r),  32'(exp_drop_r));
    checkOutput({pfx, "_drop_b"},  32'(drop_b),  32'(exp_drop_b));
  endtask

  // Scoreboard monitor: a handover happens on the coming edge.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && OUT_READY === 1'b1) begin
      if (valid_r) begin
        if (q_r.size() == 0) checkOutput("r_pop_unexpected", 32'(data_r), 32'd0);
        else checkOutput("r_data", 32'(data_r), 32'(q_r.pop_front()));
      end
      if (valid_b) begin
        if (q_b.size() == 0) checkOutput("b_pop_unexpected", 32'(data_b), 32'd0);
        else checkOutput("b_data", 32'(data_b), 32'(q_b.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    RST_N = 1'b0; EN = 1'b0; CLEAR = 1'b0; OUT_READY = 1'b0; TAP = '0;
    #12;
    checkIdle("reset");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    EN    = 1'b1;

    // Single rising hit with latency check.
    repeat (10) begin @(posedge CLK); #1; end
    applyStimulus(16'h003F, 3, 1'b0);
    checkOutput("lat_before_r", 32'(valid_r), 32'd0);
    @(posedge CLK); #1;
    checkOutput("lat_valid_r", 32'(valid_r), 32'd1);
    checkOutput("lat_valid_b", 32'(valid_b), 32'd1);
    repeat (4) begin @(posedge CLK); #1; end
    checkOutput("single_level_r", 32'(level_r), 32'd1);
    waitDrain("single");

    // Falling edges, bubble and run-off-the-end codes.
    applyStimulus(16'h0000, 6, 1'b0);
    applyStimulus(16'h00DF, 6, 1'b0);
    applyStimulus(16'h0000, 6, 1'b0);
    applyStimulus(16'hFFFF, 6, 1'b0);
    applyStimulus(16'h0000, 6, 1'b0);
    waitDrain("bubble");

    // Alternating taps with the consumer stalled: overflow and drops.
    OUT_READY = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus((i % 2) ? 16'h000F : 16'h0000, 1, 1'b0);
    repeat (6) begin @(posedge CLK); #1; end
    checkOutput("ovf_level_r", 32'(level_r), 32'(q_r.size()));
    checkOutput("ovf_level_b", 32'(level_b), 32'(q_b.size()));
    checkOutput("ovf_drop_r",  32'(drop_r),  32'(exp_drop_r));
    checkOutput("ovf_drop_b",  32'(drop_b),  32'(exp_drop_b));

    // Write into a full FIFO on the same edge as a pop.
    applyStimulus(16'h0000, 3, 1'b1);
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    checkOutput("fullpop_level_b", 32'(level_b), 32'(q_b.size()));
    checkOutput("fullpop_level_r", 32'(level_r), 32'(q_r.size()));
    checkOutput("fullpop_drop_b",  32'(drop_b),  32'(exp_drop_b));
    waitDrain("fullpop");

    // Hit captured on the edge where the coarse counter wraps.
    cyc = 0;
    while (m_coarse != 8'hFF && cyc < 300) begin @(posedge CLK); #1; cyc++; end
    applyStimulus(16'h000F, 6, 1'b0);
    applyStimulus(16'h0000, 6, 1'b0);
    waitDrain("wrap");

    // Disabled: no entries, coarse frozen, then a stamp after re-enable.
    EN = 1'b0;
    applyStimulus(16'h000F, 6, 1'b0);
    applyStimulus(16'h0000, 6, 1'b0);
    repeat (20) begin @(posedge CLK); #1; end
    checkOutput("dis_level_r", 32'(level_r), 32'd0);
    checkOutput("dis_level_b", 32'(level_b), 32'd0);
    EN = 1'b1;
    applyStimulus(16'h000F, 6, 1'b0);
    waitDrain("reenable");

    // Flush with entries queued.
    OUT_READY = 1'b0;
    applyStimulus(16'h0000, 3, 1'b0);
    applyStimulus(16'h000F, 3, 1'b0);
    applyStimulus(16'h0000, 6, 1'b0);
    checkOutput("preclr_level_b", 32'(level_b), 32'(q_b.size()));
    checkOutput("preclr_drop_b",  32'(drop_b),  32'(exp_drop_b));
    CLEAR = 1'b1;
    @(posedge CLK); #1;
    CLEAR = 1'b0;
    q_r.delete(); q_b.delete();
    exp_drop_r = 0; exp_drop_b = 0;
    checkIdle("clear");
    OUT_READY = 1'b1;
    applyStimulus(16'h000F, 6, 1'b0);
    waitDrain("postclr");

    // Asynchronous reset in the middle of traffic.
    OUT_READY = 1'b0;
    applyStimulus(16'h0000, 3, 1'b0);
    applyStimulus(16'h000F, 6, 1'b0);
    checkOutput("prerst_level_b", 32'(level_b), 32'(q_b.size()));
    #2;
    RST_N = 1'b0;
    #1;
    q_r.delete(); q_b.delete();
    exp_drop_r = 0; exp_drop_b = 0;
    checkIdle("async_rst");
    TAP = '0; tap_prev = '0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (6) begin @(posedge CLK); #1; end
    checkIdle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
